// File: rtl/cla16_multiword_seq_if.sv
// Operand/result handshake bundle for cla16_multiword_seq.
// The op_sub signal exists only when CLA_SEQ_SUB_EN is defined.
interface cla16_multiword_seq_if #(
    parameter int NWORDS = 4
);
    localparam int W = 16 * NWORDS;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         cin;
`ifdef CLA_SEQ_SUB_EN
    logic         op_sub;
`endif
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         carry_out;
    logic         overflow;

    modport master (
`ifdef CLA_SEQ_SUB_EN
        output op_sub,
`endif
        output in_valid, op_a, op_b, cin, out_ready,
        input  in_ready, out_valid, result, carry_out, overflow
    );

    modport slave (
`ifdef CLA_SEQ_SUB_EN
        input  op_sub,
`endif
        input  in_valid, op_a, op_b, cin, out_ready,
        output in_ready, out_valid, result, carry_out, overflow
    );
endinterface

// File: rtl/cla16_multiword_seq.sv
// Multi-word add (optional subtract with CLA_SEQ_SUB_EN) sequenced through one
// 16-bit two-level carry-lookahead adder, one word per clock, LSW first.
module cla16 (
    output logic [15:0] sum,
    output logic        C_out,
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic        C0
);
    // Returns {c4,c3,c2,c1,c0} for a 4-bit lookahead group.
    function automatic logic [4:0] lookahead4(input logic [3:0] g, input logic [3:0] p, input logic c0);
        logic [4:0] c;
        c[0] = c0;
        c[1] = g[0] | (p[0] & c0);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c0);
        return c;
    endfunction

    logic [15:0] g_s;
    logic [15:0] p_s;
    logic [15:0] c_s;
    logic [3:0]  gg_s;
    logic [3:0]  gp_s;
    logic [4:0]  gc_s;

    // Bit generate/propagate, group lookahead, then per-bit carries.
    always_comb begin
        logic [4:0] t;
        g_s  = A & B;
        p_s  = A ^ B;
        gg_s = 4'b0000;
        gp_s = 4'b0000;
        c_s  = 16'h0000;
        for (int j = 0; j < 4; j++) begin
            t       = lookahead4(g_s[4*j +: 4], p_s[4*j +: 4], 1'b0);
            gg_s[j] = t[4];
            gp_s[j] = &p_s[4*j +: 4];
        end
        gc_s = lookahead4(gg_s, gp_s, C0);
        for (int j = 0; j < 4; j++) begin
            t              = lookahead4(g_s[4*j +: 4], p_s[4*j +: 4], gc_s[j]);
            c_s[4*j +: 4] = t[3:0];
        end
        sum   = p_s ^ c_s;
        C_out = gc_s[4];
    end
endmodule

module cla16_multiword_seq #(
    parameter int NWORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    cla16_multiword_seq_if.slave  bus
);
    localparam int W  = 16 * NWORDS;
    localparam int CW = $clog2(NWORDS);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          carry_q, carry_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic          cin_q, cin_d;
`ifdef CLA_SEQ_SUB_EN
    logic          sub_q, sub_d;
`endif
    logic [W-1:0]  result_q, result_d;
    logic          carry_out_q, carry_out_d;
    logic          overflow_q, overflow_d;
    logic          out_valid_q, out_valid_d;
    logic          in_ready_q, in_ready_d;

    logic [15:0]   word_a_s;
    logic [15:0]   word_b_s;
    logic          c0_s;
    logic          b_msb_s;
    logic [15:0]   sum_s;
    logic          cout_s;
    logic          last_s;

    // Select the current word pair and carry-in for the shared adder.
    always_comb begin
        word_a_s = a_q[{cnt_q, 4'b0000} +: 16];
        word_b_s = b_q[{cnt_q, 4'b0000} +: 16];
        last_s   = (cnt_q == CW'(NWORDS - 1));
`ifdef CLA_SEQ_SUB_EN
        // Subtract is A + ~B + 1; cin is ignored in that mode.
        if (sub_q) begin
            word_b_s = ~word_b_s;
        end else begin
            word_b_s = word_b_s;
        end
        c0_s    = (cnt_q == {CW{1'b0}}) ? (sub_q | cin_q) : carry_q;
        b_msb_s = b_q[W-1] ^ sub_q;
`else
        c0_s    = (cnt_q == {CW{1'b0}}) ? cin_q : carry_q;
        b_msb_s = b_q[W-1];
`endif
    end

    cla16 u_cla16 (
        .sum   (sum_s),
        .C_out (cout_s),
        .A     (word_a_s),
        .B     (word_b_s),
        .C0    (c0_s)
    );

    // Sequencer next-state and datapath updates.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        a_d         = a_q;
        b_d         = b_q;
        cin_d       = cin_q;
`ifdef CLA_SEQ_SUB_EN
        sub_d       = sub_q;
`endif
        result_d    = result_q;
        carry_out_d = carry_out_q;
        overflow_d  = overflow_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    a_d        = bus.op_a;
                    b_d        = bus.op_b;
                    cin_d      = bus.cin;
`ifdef CLA_SEQ_SUB_EN
                    sub_d      = bus.op_sub;
`endif
                    cnt_d      = {CW{1'b0}};
                    in_ready_d = 1'b0;
                    state_d    = RUN;
                end else begin
                    state_d    = IDLE;
                end
            end
            RUN: begin
                result_d[{cnt_q, 4'b0000} +: 16] = sum_s;
                carry_d = cout_s;
                if (last_s) begin
                    cnt_d       = {CW{1'b0}};
                    carry_out_d = cout_s;
                    overflow_d  = (a_q[W-1] == b_msb_s) && (sum_s[15] != a_q[W-1]);
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    cnt_d       = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end else begin
                    state_d     = DONE;
                end
            end
            default: begin
                cnt_d       = {CW{1'b0}};
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= {CW{1'b0}};
            carry_q     <= 1'b0;
            a_q         <= {W{1'b0}};
            b_q         <= {W{1'b0}};
            cin_q       <= 1'b0;
`ifdef CLA_SEQ_SUB_EN
            sub_q       <= 1'b0;
`endif
            result_q    <= {W{1'b0}};
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            a_q         <= a_d;
            b_q         <= b_d;
            cin_q       <= cin_d;
`ifdef CLA_SEQ_SUB_EN
            sub_q       <= sub_d;
`endif
            result_q    <= result_d;
            carry_out_q <= carry_out_d;
            overflow_q  <= overflow_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.carry_out = carry_out_q;
    assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_cla16_multiword_seq.sv
// Directed scoreboard bench for cla16_multiword_seq (NWORDS=4).
module tb_cla16_multiword_seq;
    localparam int NWORDS = 4;
    localparam int W      = 16 * NWORDS;

    typedef struct packed {
        logic [W-1:0] res;
        logic         co;
        logic         ov;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   passed = 0;
    int   total  = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    cla16_multiword_seq_if #(.NWORDS(NWORDS)) bus ();

    cla16_multiword_seq #(.NWORDS(NWORDS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic c, input logic sub);
        exp_t         e;
        logic [W-1:0] bb;
        logic [W:0]   s;
        logic         ci;
        bb   = sub ? ~b : b;
        ci   = sub ? 1'b1 : c;
        s    = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, ci};
        e.res = s[W-1:0];
        e.co  = s[W];
        e.ov  = (a[W-1] == bb[W-1]) && (s[W-1] != a[W-1]);
        return e;
    endfunction

    // Drive one operation, push its expectation, wait for out_valid and check latency.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input logic sub);
        int n;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_before_accept", W'(bus.in_ready), W'(1));
        bus.in_valid = 1'b1;
        bus.op_a     = a;
        bus.op_b     = b;
        bus.cin      = c;
`ifdef CLA_SEQ_SUB_EN
        bus.op_sub   = sub;
`endif
        sb_q.push_back(model(a, b, c, sub));
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("in_ready_after_accept", W'(bus.in_ready), W'(0));
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("latency_edges", W'(n), W'(NWORDS));
    endtask

    // Compare the held result against the scoreboard, then complete the handshake.
    task automatic retire(input string tag);
        exp_t e;
        chk({tag, "_sb_nonempty"}, W'(sb_q.size() != 0), W'(1));
        e = (sb_q.size() != 0) ? sb_q.pop_front() : '0;
        chk({tag, "_out_valid"}, W'(bus.out_valid), W'(1));
        chk({tag, "_result"}, bus.result, e.res);
        chk({tag, "_carry_out"}, W'(bus.carry_out), W'(e.co));
        chk({tag, "_overflow"}, W'(bus.overflow), W'(e.ov));
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk({tag, "_out_valid_drop"}, W'(bus.out_valid), W'(0));
        chk({tag, "_in_ready_back"}, W'(bus.in_ready), W'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t snap;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.op_a      = {W{1'b0}};
        bus.op_b      = {W{1'b0}};
        bus.cin       = 1'b0;
        bus.out_ready = 1'b1;
`ifdef CLA_SEQ_SUB_EN
        bus.op_sub    = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_in_ready", W'(bus.in_ready), W'(1));
        chk("rst_out_valid", W'(bus.out_valid), W'(0));
        chk("rst_result", bus.result, {W{1'b0}});
        chk("rst_carry_out", W'(bus.carry_out), W'(0));
        chk("rst_overflow", W'(bus.overflow), W'(0));
        rst_n = 1'b1;
        @(negedge clk);

        issue(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0);
        retire("word_carry");
        issue(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
        retire("full_ripple");
        issue(64'h7FFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0);
        retire("pos_overflow");
        issue(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0);
        retire("neg_overflow");
        for (int i = 0; i < 4; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            issue(ra, rb, i[0], 1'b0);
            retire("random");
        end

        bus.out_ready = 1'b0;
        issue(64'h1234_5678_9ABC_DEF0, 64'h1111_2222_3333_4444, 1'b1, 1'b0);
        snap = sb_q[0];
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.op_a     = {$urandom, $urandom};
            @(negedge clk);
            chk("stall_out_valid", W'(bus.out_valid), W'(1));
            chk("stall_result", bus.result, snap.res);
            chk("stall_carry_out", W'(bus.carry_out), W'(snap.co));
            chk("stall_in_ready", W'(bus.in_ready), W'(0));
        end
        bus.in_valid = 1'b0;
        retire("stall");
        repeat (8) @(negedge clk);
        chk("stall_no_extra_op", W'(bus.out_valid), W'(0));
        chk("stall_sb_empty", W'(sb_q.size()), W'(0));

        bus.in_valid = 1'b1;
        bus.op_a     = 64'hFFFF_FFFF_FFFF_FFFF;
        bus.op_b     = 64'h1;
        bus.cin      = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", W'(bus.out_valid), W'(0));
        chk("abort_result", bus.result, {W{1'b0}});
        chk("abort_in_ready", W'(bus.in_ready), W'(1));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_released_out_valid", W'(bus.out_valid), W'(0));
        issue(64'h3, 64'h4, 1'b0, 1'b0);
        retire("after_abort");

`ifdef CLA_SEQ_SUB_EN
        issue(64'h0, 64'h1, 1'b0, 1'b1);
        retire("sub_borrow");
        issue(64'h5, 64'h3, 1'b0, 1'b1);
        retire("sub_no_borrow");
        issue(64'h8000_0000_0000_0000, 64'h1, 1'b1, 1'b1);
        retire("sub_overflow");
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
